// File: rtl/pipe_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_hazard_ctrl
//
// Central stall/flush controller for a classic 5-stage pipeline
// (IF, ID, EX, MEM, WB). It drives the load enables and bubble (NOP-insert)
// controls of the PC and of the four pipeline registers. It resolves four
// kinds of events:
//   * data-memory wait states (dmem_stall)
//   * multi-cycle multiply occupancy of EX (ex_mul_start / MUL_WAIT state)
//   * taken-branch flushes (ex_branch_taken)
//   * load-use data hazards
// A saturating counter records the number of cycles in which the PC was held.
//
// Parameters:
//   MUL_LAT  total EX cycles a multiply occupies, including its start cycle
//            (legal range 1..15)
//   CNT_W    width of stall_count
//
// Ports:
//   clock            pipeline clock, rising edge
//   reset            synchronous, active-high
//   id_rs, id_rt     source register fields of the instruction in ID
//   id_uses_rs/_rt   the ID instruction actually reads rs / rt
//   idex_memread     the instruction in EX is a load
//   idex_rt          destination register of that load
//   ex_branch_taken  EX resolved a taken branch or jump
//   ex_mul_start     a multiply is in EX this cycle
//   dmem_stall       data memory not ready; MEM must hold
//   pc_en            PC load enable
//   ifid_en/_flush   IF/ID load enable / load NOP
//   idex_en/_bubble  ID/EX load enable / load NOP
//   exmem_en/_bubble EX/MEM load enable / load NOP
//   memwb_en/_bubble MEM/WB load enable / load NOP
//   mul_busy         multiply stall in progress
//   stall_count      saturating count of cycles with pc_en=0 since reset
// -----------------------------------------------------------------------------
module pipe_hazard_ctrl #(
    parameter int MUL_LAT = 4,
    parameter int CNT_W   = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_uses_rs,
    input  logic             id_uses_rt,
    input  logic             idex_memread,
    input  logic [4:0]       idex_rt,
    input  logic             ex_branch_taken,
    input  logic             ex_mul_start,
    input  logic             dmem_stall,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             ifid_flush,
    output logic             idex_en,
    output logic             idex_bubble,
    output logic             exmem_en,
    output logic             exmem_bubble,
    output logic             memwb_en,
    output logic             memwb_bubble,
    output logic             mul_busy,
    output logic [CNT_W-1:0] stall_count
);

    typedef enum logic {
        RUN      = 1'b0,
        MUL_WAIT = 1'b1
    } state_e;

    // Number of stall cycles that follow the multiply start cycle.
    localparam logic [3:0]       MUL_INIT = 4'(MUL_LAT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    state_e           state_q, state_d;
    logic [3:0]       mcnt_q, mcnt_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    logic rs_hit;
    logic rt_hit;
    logic load_use;

    // -------------------------------------------------------------------------
    // Load-use detection. Register 0 is hard-wired to zero, so a load that
    // targets it can never produce a value the ID instruction depends on.
    // -------------------------------------------------------------------------
    assign rs_hit   = id_uses_rs && (id_rs == idex_rt);
    assign rt_hit   = id_uses_rt && (id_rt == idex_rt);
    assign load_use = idex_memread && (idex_rt != 5'd0) && (rs_hit || rt_hit);

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= RUN;
            mcnt_q      <= 4'd0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            mcnt_q      <= mcnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        mcnt_d  = mcnt_q;
        // A memory wait freezes the whole front of the pipe, including the
        // multiply instruction in EX, so the sequencer must freeze with it.
        if (!dmem_stall) begin
            case (state_q)
                RUN: begin
                    // With a single-cycle multiply the start cycle is the
                    // whole operation and no wait state is needed.
                    if (ex_mul_start && (MUL_LAT > 1)) begin
                        state_d = MUL_WAIT;
                        mcnt_d  = MUL_INIT;
                    end
                end
                MUL_WAIT: begin
                    // mcnt==1 marks the last stall cycle. The <= also guards
                    // against an unreachable zero value trapping the FSM.
                    if (mcnt_q <= 4'd1) begin
                        state_d = RUN;
                        mcnt_d  = 4'd0;
                    end else begin
                        mcnt_d = mcnt_q - 4'd1;
                    end
                end
                default: begin
                    state_d = RUN;
                    mcnt_d  = 4'd0;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Output logic: priority reset > dmem_stall > MUL_WAIT > branch > load-use
    // -------------------------------------------------------------------------
    always_comb begin
        pc_en        = 1'b1;
        ifid_en      = 1'b1;
        ifid_flush   = 1'b0;
        idex_en      = 1'b1;
        idex_bubble  = 1'b0;
        exmem_en     = 1'b1;
        exmem_bubble = 1'b0;
        memwb_en     = 1'b1;
        memwb_bubble = 1'b0;
        mul_busy     = 1'b0;

        if (reset) begin
            pc_en        = 1'b0;
            ifid_en      = 1'b0;
            ifid_flush   = 1'b1;
            idex_en      = 1'b0;
            idex_bubble  = 1'b1;
            exmem_en     = 1'b0;
            exmem_bubble = 1'b1;
            memwb_en     = 1'b0;
            memwb_bubble = 1'b1;
        end else if (dmem_stall) begin
            // Hold everything up to and including EX/MEM; WB drains a NOP so
            // the instruction leaving MEM is not written back twice.
            pc_en        = 1'b0;
            ifid_en      = 1'b0;
            idex_en      = 1'b0;
            exmem_en     = 1'b0;
            memwb_bubble = 1'b1;
            // A multiply interrupted by a memory wait is still in progress.
            mul_busy     = (state_q == MUL_WAIT);
        end else if (state_q == MUL_WAIT) begin
            // EX is occupied; keep the front end frozen and feed NOPs to MEM.
            pc_en        = 1'b0;
            ifid_en      = 1'b0;
            idex_en      = 1'b0;
            exmem_bubble = 1'b1;
            mul_busy     = 1'b1;
        end else if (ex_branch_taken) begin
            // PC loads the target; the two wrong-path instructions in IF and
            // ID are squashed, which also cancels any load-use hazard of the
            // ID instruction.
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
        end else if (load_use) begin
            // One bubble: next cycle the load is in MEM and forwarding covers it.
            pc_en       = 1'b0;
            ifid_en     = 1'b0;
            idex_bubble = 1'b1;
        end
    end

    // -------------------------------------------------------------------------
    // Stall-cycle counter (saturating)
    // -------------------------------------------------------------------------
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (!pc_en && (stall_cnt_q != CNT_MAX)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    assign stall_count = stall_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// Testbench for pipe_hazard_ctrl.
// Two instances share the stimulus: dut_a uses the default parameters
// (MUL_LAT=4, CNT_W=16) and dut_b uses MUL_LAT=1, CNT_W=4 to exercise the
// single-cycle multiply and counter saturation.
// Control outputs are packed as
//   {pc_en, ifid_en, ifid_flush, idex_en, idex_bubble,
//    exmem_en, exmem_bubble, memwb_en, memwb_bubble, mul_busy}.
// -----------------------------------------------------------------------------
module tb_pipe_hazard_ctrl;

    localparam logic [9:0] C_RESET = 10'b0010101010;
    localparam logic [9:0] C_IDLE  = 10'b1101010100;
    localparam logic [9:0] C_LU    = 10'b0001110100;
    localparam logic [9:0] C_BR    = 10'b1111110100;
    localparam logic [9:0] C_MUL   = 10'b0000011101;
    localparam logic [9:0] C_DM    = 10'b0000000110;
    localparam logic [9:0] C_DMM   = 10'b0000000111;
    localparam logic [20:0] S_IDLE = 21'd0;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [4:0] id_rs = '0, id_rt = '0, idex_rt = '0;
    logic       id_uses_rs = 1'b0, id_uses_rt = 1'b0, idex_memread = 1'b0;
    logic       ex_branch_taken = 1'b0, ex_mul_start = 1'b0, dmem_stall = 1'b0;

    logic a_pc_en, a_ifid_en, a_ifid_flush, a_idex_en, a_idex_bubble;
    logic a_exmem_en, a_exmem_bubble, a_memwb_en, a_memwb_bubble, a_mul_busy;
    logic [15:0] a_stall_count;
    logic b_pc_en, b_ifid_en, b_ifid_flush, b_idex_en, b_idex_bubble;
    logic b_exmem_en, b_exmem_bubble, b_memwb_en, b_memwb_bubble, b_mul_busy;
    logic [3:0] b_stall_count;

    logic [9:0] ctl_a, ctl_b;
    assign ctl_a = {a_pc_en, a_ifid_en, a_ifid_flush, a_idex_en, a_idex_bubble,
                    a_exmem_en, a_exmem_bubble, a_memwb_en, a_memwb_bubble, a_mul_busy};
    assign ctl_b = {b_pc_en, b_ifid_en, b_ifid_flush, b_idex_en, b_idex_bubble,
                    b_exmem_en, b_exmem_bubble, b_memwb_en, b_memwb_bubble, b_mul_busy};

    pipe_hazard_ctrl #(.MUL_LAT(4), .CNT_W(16)) dut_a (
        .clock(clk), .reset(rst), .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
        .idex_memread(idex_memread), .idex_rt(idex_rt),
        .ex_branch_taken(ex_branch_taken), .ex_mul_start(ex_mul_start),
        .dmem_stall(dmem_stall),
        .pc_en(a_pc_en), .ifid_en(a_ifid_en), .ifid_flush(a_ifid_flush),
        .idex_en(a_idex_en), .idex_bubble(a_idex_bubble),
        .exmem_en(a_exmem_en), .exmem_bubble(a_exmem_bubble),
        .memwb_en(a_memwb_en), .memwb_bubble(a_memwb_bubble),
        .mul_busy(a_mul_busy), .stall_count(a_stall_count)
    );

    pipe_hazard_ctrl #(.MUL_LAT(1), .CNT_W(4)) dut_b (
        .clock(clk), .reset(rst), .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
        .idex_memread(idex_memread), .idex_rt(idex_rt),
        .ex_branch_taken(ex_branch_taken), .ex_mul_start(ex_mul_start),
        .dmem_stall(dmem_stall),
        .pc_en(b_pc_en), .ifid_en(b_ifid_en), .ifid_flush(b_ifid_flush),
        .idex_en(b_idex_en), .idex_bubble(b_idex_bubble),
        .exmem_en(b_exmem_en), .exmem_bubble(b_exmem_bubble),
        .memwb_en(b_memwb_en), .memwb_bubble(b_memwb_bubble),
        .mul_busy(b_mul_busy), .stall_count(b_stall_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [9:0]  ctl;
        logic [9:0]  ctl2;
        logic [15:0] cnt;
        logic [3:0]  cnt2;
        string       name;
    } exp_t;

    exp_t        sb[$];
    exp_t        e;
    logic [15:0] exp_cnt  = '0;
    logic [3:0]  exp_cnt2 = '0;

    function automatic logic [20:0] mk(input logic mr, input logic [4:0] xrt,
                                       input logic [4:0] rs, input logic [4:0] rt,
                                       input logic urs, input logic urt,
                                       input logic br, input logic ms, input logic dm);
        return {mr, xrt, rs, rt, urs, urt, br, ms, dm};
    endfunction

    // Drive one cycle of stimulus and record what both instances must show.
    task automatic drive_and_push(input logic r, input logic [20:0] st,
                                  input logic [9:0] c, input logic [9:0] c2,
                                  input string nm);
        exp_t x;
        rst = r;
        {idex_memread, idex_rt, id_rs, id_rt, id_uses_rs, id_uses_rt,
         ex_branch_taken, ex_mul_start, dmem_stall} = st;
        x.ctl  = c;
        x.ctl2 = c2;
        x.cnt  = exp_cnt;
        x.cnt2 = exp_cnt2;
        x.name = nm;
        sb.push_back(x);
    endtask

    // Clock edge; update the reference stall counters from the expected pc_en.
    task automatic advance(input logic p1, input logic p2);
        @(posedge clk);
        if (rst) begin
            exp_cnt  = '0;
            exp_cnt2 = '0;
        end else begin
            if (!p1 && exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
            if (!p2 && exp_cnt2 != 4'hF) exp_cnt2 = exp_cnt2 + 4'd1;
        end
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 5; i++) begin
            drive_and_push(i < 3, S_IDLE, (i < 3) ? C_RESET : C_IDLE,
                           (i < 3) ? C_RESET : C_IDLE, $sformatf("reset[%0d]", i));
            @(negedge clk);
            e = sb.pop_front();
            checks++;
            if (ctl_a !== e.ctl) begin
                errors++;
                $display("FAIL %s ctl got=%b exp=%b", e.name, ctl_a, e.ctl);
            end
            // stall_count is undefined until the first reset edge.
            if (i > 0) begin
                checks++;
                if (a_stall_count !== e.cnt) begin
                    errors++;
                    $display("FAIL %s stall_count got=%0d exp=%0d", e.name, a_stall_count, e.cnt);
                end
            end
            $display("%s ctl=%b stall_count=%0d", e.name, ctl_a, a_stall_count);
            advance(e.ctl[9], e.ctl2[9]);
        end
    endtask

    task automatic test_load_use();
        logic [20:0] st [6];
        logic [9:0]  ce [6];
        st = '{mk(1, 8, 8, 0, 1, 0, 0, 0, 0),   // rs hit
               S_IDLE,                          // load moved to MEM
               mk(1, 0, 0, 0, 1, 1, 0, 0, 0),   // $zero never hazards
               mk(1, 9, 3, 9, 1, 1, 0, 0, 0),   // rt hit
               mk(1, 9, 9, 9, 0, 0, 0, 0, 0),   // fields match but unused
               mk(0, 8, 8, 8, 1, 1, 0, 0, 0)};  // not a load
        ce = '{C_LU, C_IDLE, C_IDLE, C_LU, C_IDLE, C_IDLE};
        for (int i = 0; i < 6; i++) begin
            drive_and_push(1'b0, st[i], ce[i], ce[i], $sformatf("load_use[%0d]", i));
            @(negedge clk);
            e = sb.pop_front();
            checks++;
            if (ctl_a !== e.ctl) begin
                errors++;
                $display("FAIL %s ctl got=%b exp=%b", e.name, ctl_a, e.ctl);
            end
            checks++;
            if (a_stall_count !== e.cnt) begin
                errors++;
                $display("FAIL %s stall_count got=%0d exp=%0d", e.name, a_stall_count, e.cnt);
            end
            $display("%s ctl=%b stall_count=%0d", e.name, ctl_a, a_stall_count);
            advance(e.ctl[9], e.ctl2[9]);
        end
    endtask

    task automatic test_branch();
        logic [20:0] st [4];
        logic [9:0]  ce [4];
        st = '{mk(1, 8, 8, 0, 1, 0, 1, 0, 0),   // branch beats load-use
               mk(1, 8, 8, 0, 1, 0, 1, 0, 1),   // dmem_stall beats branch
               mk(1, 8, 8, 0, 1, 0, 1, 0, 0),   // branch re-presented
               S_IDLE};
        ce = '{C_BR, C_DM, C_BR, C_IDLE};
        for (int i = 0; i < 4; i++) begin
            drive_and_push(1'b0, st[i], ce[i], ce[i], $sformatf("branch[%0d]", i));
            @(negedge clk);
            e = sb.pop_front();
            checks++;
            if (ctl_a !== e.ctl) begin
                errors++;
                $display("FAIL %s ctl got=%b exp=%b", e.name, ctl_a, e.ctl);
            end
            checks++;
            if (a_stall_count !== e.cnt) begin
                errors++;
                $display("FAIL %s stall_count got=%0d exp=%0d", e.name, a_stall_count, e.cnt);
            end
            $display("%s ctl=%b stall_count=%0d", e.name, ctl_a, a_stall_count);
            advance(e.ctl[9], e.ctl2[9]);
        end
    endtask

    task automatic test_mul();
        logic [20:0] st [6];
        logic [9:0]  ce [6];
        logic [9:0]  c2 [6];
        st = '{mk(0, 0, 0, 0, 0, 0, 0, 1, 0),   // start cycle, no stall
               mk(0, 0, 0, 0, 0, 0, 0, 1, 0),
               mk(1, 8, 8, 0, 1, 0, 0, 1, 0),   // load-use masked by MUL_WAIT
               mk(0, 0, 0, 0, 0, 0, 0, 1, 0),   // last stall cycle
               S_IDLE,
               S_IDLE};
        ce = '{C_IDLE, C_MUL, C_MUL, C_MUL, C_IDLE, C_IDLE};
        c2 = '{C_IDLE, C_IDLE, C_LU, C_IDLE, C_IDLE, C_IDLE};
        for (int i = 0; i < 6; i++) begin
            drive_and_push(1'b0, st[i], ce[i], c2[i], $sformatf("mul[%0d]", i));
            @(negedge clk);
            e = sb.pop_front();
            checks++;
            if (ctl_a !== e.ctl) begin
                errors++;
                $display("FAIL %s ctl got=%b exp=%b", e.name, ctl_a, e.ctl);
            end
            checks++;
            if (a_stall_count !== e.cnt) begin
                errors++;
                $display("FAIL %s stall_count got=%0d exp=%0d", e.name, a_stall_count, e.cnt);
            end
            checks++;
            if (ctl_b !== e.ctl2) begin
                errors++;
                $display("FAIL %s lat1_ctl got=%b exp=%b", e.name, ctl_b, e.ctl2);
            end
            $display("%s ctl=%b lat1_ctl=%b stall_count=%0d", e.name, ctl_a, ctl_b, a_stall_count);
            advance(e.ctl[9], e.ctl2[9]);
        end
    endtask

    task automatic test_mul_dmem();
        logic [20:0] st [8];
        logic [9:0]  ce [8];
        logic [9:0]  c2 [8];
        logic        rr [8];
        rr = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        st = '{S_IDLE,
               mk(0, 0, 0, 0, 0, 0, 0, 1, 0),   // start, mcnt <- 3
               mk(0, 0, 0, 0, 0, 0, 0, 1, 0),   // mcnt 3 -> 2
               mk(0, 0, 0, 0, 0, 0, 0, 1, 1),   // frozen at 2
               mk(0, 0, 0, 0, 0, 0, 0, 1, 1),   // frozen at 2
               mk(0, 0, 0, 0, 0, 0, 0, 1, 0),   // 2 -> 1
               mk(0, 0, 0, 0, 0, 0, 0, 1, 0),   // last stall
               S_IDLE};
        ce = '{C_RESET, C_IDLE, C_MUL, C_DMM, C_DMM, C_MUL, C_MUL, C_IDLE};
        c2 = '{C_RESET, C_IDLE, C_IDLE, C_DM, C_DM, C_IDLE, C_IDLE, C_IDLE};
        for (int i = 0; i < 8; i++) begin
            drive_and_push(rr[i], st[i], ce[i], c2[i], $sformatf("mul_dmem[%0d]", i));
            @(negedge clk);
            e = sb.pop_front();
            checks++;
            if (ctl_a !== e.ctl) begin
                errors++;
                $display("FAIL %s ctl got=%b exp=%b", e.name, ctl_a, e.ctl);
            end
            checks++;
            if (a_stall_count !== e.cnt) begin
                errors++;
                $display("FAIL %s stall_count got=%0d exp=%0d", e.name, a_stall_count, e.cnt);
            end
            $display("%s ctl=%b stall_count=%0d", e.name, ctl_a, a_stall_count);
            advance(e.ctl[9], e.ctl2[9]);
        end
        checks++;
        if (a_stall_count !== 16'd5) begin
            errors++;
            $display("FAIL mul_dmem_total stall_count got=%0d exp=5", a_stall_count);
        end
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 23; i++) begin
            if (i == 0)
                drive_and_push(1'b1, S_IDLE, C_RESET, C_RESET, "sat_reset");
            else if (i <= 20)
                drive_and_push(1'b0, mk(0, 0, 0, 0, 0, 0, 0, 0, 1), C_DM, C_DM,
                               $sformatf("sat_dmem[%0d]", i));
            else
                drive_and_push(1'b0, S_IDLE, C_IDLE, C_IDLE, $sformatf("sat_idle[%0d]", i));
            @(negedge clk);
            e = sb.pop_front();
            checks++;
            if (ctl_b !== e.ctl2) begin
                errors++;
                $display("FAIL %s lat1_ctl got=%b exp=%b", e.name, ctl_b, e.ctl2);
            end
            // From the first post-reset cycle on, the 4-bit counter is defined.
            if (i > 0) begin
                checks++;
                if (b_stall_count !== e.cnt2) begin
                    errors++;
                    $display("FAIL %s cnt4 got=%0d exp=%0d", e.name, b_stall_count, e.cnt2);
                end
            end
            $display("%s lat1_ctl=%b cnt4=%0d", e.name, ctl_b, b_stall_count);
            advance(e.ctl[9], e.ctl2[9]);
        end
        checks++;
        if (b_stall_count !== 4'd15) begin
            errors++;
            $display("FAIL sat_final cnt4 got=%0d exp=15", b_stall_count);
        end
    endtask

    task automatic test_reset_mid_mul();
        logic [20:0] st [5];
        logic [9:0]  ce [5];
        logic        rr [5];
        rr = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        st = '{mk(0, 0, 0, 0, 0, 0, 0, 1, 0),
               mk(0, 0, 0, 0, 0, 0, 0, 1, 0),
               mk(0, 0, 0, 0, 0, 0, 0, 1, 0),   // reset while in MUL_WAIT
               S_IDLE,
               S_IDLE};
        ce = '{C_IDLE, C_MUL, C_RESET, C_IDLE, C_IDLE};
        for (int i = 0; i < 5; i++) begin
            drive_and_push(rr[i], st[i], ce[i], ce[i], $sformatf("reset_mul[%0d]", i));
            @(negedge clk);
            e = sb.pop_front();
            checks++;
            if (ctl_a !== e.ctl) begin
                errors++;
                $display("FAIL %s ctl got=%b exp=%b", e.name, ctl_a, e.ctl);
            end
            checks++;
            if (a_stall_count !== e.cnt) begin
                errors++;
                $display("FAIL %s stall_count got=%0d exp=%0d", e.name, a_stall_count, e.cnt);
            end
            $display("%s ctl=%b stall_count=%0d", e.name, ctl_a, a_stall_count);
            advance(e.ctl[9], e.ctl2[9]);
        end
    endtask

    initial begin
        #1;
        test_reset();
        test_load_use();
        test_branch();
        test_mul();
        test_mul_dmem();
        test_saturation();
        test_reset_mid_mul();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_empty got=%0d exp=0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
